clog2_field_unpacker: RTL

//  Serial receiver for width-prefixed magnitude fields: the decode side of the ceil(log2) bit-cost

---
 rtl/clog2_field_unpacker.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/clog2_field_unpacker.sv
// Serial receiver for width-prefixed magnitude fields: a header w (LSB first), then w bits of x-1.
// Rebuilds x, offers it on a valid/ready port, and discards malformed frames with an error pulse.
module clog2_field_unpacker #(
  parameter int HDR_W  = 4,
  parameter int VAL_W  = 8,
  parameter int MAX_W  = 8,
  parameter int ERR_CW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [VAL_W-1:0]  out_value,
  output logic [HDR_W-1:0]  out_width,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_pulse,
  output logic [1:0]        err_code,
  output logic [ERR_CW-1:0] err_count,
  output logic              busy
);

  localparam int CNT_W = $clog2((HDR_W > MAX_W ? HDR_W : MAX_W) + 1);

  localparam logic [1:0] S_HDR  = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HDR_W-1:0]  hdr_q, hdr_d;
  logic [HDR_W-1:0]  w_q, w_d;
  logic [VAL_W-1:0]  fld_q, fld_d;
  logic [VAL_W-1:0]  val_q, val_d;
  logic [HDR_W-1:0]  wid_q, wid_d;
  logic              ep_q, ep_d;
  logic [1:0]        ec_q, ec_d;
  logic [ERR_CW-1:0] ecnt_q, ecnt_d;

  logic              take;
  logic [HDR_W-1:0]  hdr_full;
  logic [VAL_W-1:0]  fld_full;
  logic [VAL_W:0]    sum;

  assign bit_ready = rst_n & (state_q != S_OUT);
  assign take      = bit_valid & bit_ready;
  assign hdr_full  = {bit_in, hdr_q[HDR_W-1:1]};
  assign fld_full  = fld_q | (VAL_W'(bit_in) << cnt_q);
  // One extra bit so that f = all-ones is detected as an unrepresentable x.
  assign sum       = {1'b0, fld_full} + (VAL_W+1)'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    w_d     = w_q;
    fld_d   = fld_q;
    val_d   = val_q;
    wid_d   = wid_q;
    ep_d    = 1'b0;
    ec_d    = 2'b00;
    ecnt_d  = ecnt_q;
    case (state_q)
      S_HDR: begin
        if (take) begin
          if (cnt_q == CNT_W'(HDR_W - 1)) begin
            cnt_d = '0;
            hdr_d = '0;
            if (hdr_full == '0) begin
              val_d   = '0;
              wid_d   = '0;
              state_d = S_OUT;
            end else if (hdr_full > HDR_W'(MAX_W)) begin
              ep_d = 1'b1;
              ec_d = 2'b01;
            end else begin
              w_d     = hdr_full;
              fld_d   = '0;
              state_d = S_DATA;
            end
          end else begin
            hdr_d = hdr_full;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DATA: begin
        if (take) begin
          if (cnt_q == CNT_W'(w_q) - CNT_W'(1)) begin
            cnt_d   = '0;
            fld_d   = '0;
            state_d = S_HDR;
            if (sum[VAL_W]) begin
              ep_d = 1'b1;
              ec_d = 2'b10;
            end else begin
              val_d   = sum[VAL_W-1:0];
              wid_d   = w_q;
              state_d = S_OUT;
            end
          end else begin
            fld_d = fld_full;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase
    if (ep_d && (ecnt_q != {ERR_CW{1'b1}})) ecnt_d = ecnt_q + ERR_CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HDR;
      cnt_q   <= '0;
      hdr_q   <= '0;
      w_q     <= '0;
      fld_q   <= '0;
      val_q   <= '0;
      wid_q   <= '0;
      ep_q    <= 1'b0;
      ec_q    <= 2'b00;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      w_q     <= w_d;
      fld_q   <= fld_d;
      val_q   <= val_d;
      wid_q   <= wid_d;
      ep_q    <= ep_d;
      ec_q    <= ec_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign out_value = val_q;
  assign out_width = wid_q;
  assign out_valid = (state_q == S_OUT);
  assign err_pulse = ep_q;
  assign err_code  = ec_q;
  assign err_count = ecnt_q;
  assign busy      = (state_q != S_HDR) || (cnt_q != '0);

endmodule
